// File: rtl/next_pc_unit.sv
// Next-PC generator: direct-mapped BTB lookup, EX branch resolution, mispredict redirect.
// Optional 2-bit direction counters are enabled by defining NPC_BHT_EN.
module next_pc_unit #(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic [31:0] pc_next,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        flush
);

    localparam int IDX  = $clog2(BTB_ENTRIES);
    localparam int TAGW = 30 - IDX;

    logic            valid_q  [BTB_ENTRIES];
    logic [TAGW-1:0] tag_q    [BTB_ENTRIES];
    logic [31:0]     target_q [BTB_ENTRIES];
`ifdef NPC_BHT_EN
    logic [1:0]      ctr_q    [BTB_ENTRIES];
    logic [1:0]      wr_ctr;
`endif

    logic            pend_valid_q, pend_valid_d;
    logic [31:0]     pend_addr_q,  pend_addr_d;

    logic [IDX-1:0]  rd_idx, ex_idx;
    logic            rd_hit, ex_hit;
    logic            mis;
    logic [31:0]     redir;

    logic            wr_en;
    logic            wr_valid;
    logic [TAGW-1:0] wr_tag;
    logic [31:0]     wr_target;

    assign rd_idx = pc[IDX+1:2];
    assign ex_idx = ex_pc[IDX+1:2];
    assign rd_hit = valid_q[rd_idx] && (tag_q[rd_idx] == pc[31:IDX+2]);
    assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_pc[31:IDX+2]);

    // Lookup sees pre-edge array contents, so same-index update is invisible until next cycle.
    always_comb begin
`ifdef NPC_BHT_EN
        pred_taken = rd_hit && ctr_q[rd_idx][1];
`else
        pred_taken = rd_hit;
`endif
        pred_target = pred_taken ? target_q[rd_idx] : pc + 32'd4;
    end

    always_comb begin
        mis = 1'b0;
        if (ex_valid) begin
            if (ex_is_branch)
                mis = (ex_taken != ex_pred_taken) ||
                      (ex_taken && (ex_target != ex_pred_target));
            else
                mis = ex_pred_taken;
        end
        redir = (ex_taken && ex_is_branch) ? ex_target : ex_pc + 32'd4;
        flush = mis;
    end

    always_comb begin
        if (mis)
            pc_next = redir;
        else if (pend_valid_q)
            pc_next = pend_addr_q;
        else
            pc_next = pred_target;
    end

    // A stalled mispredict is parked until fetch is released.
    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (mis && stall) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = redir;
        end else if (!stall) begin
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        wr_en     = 1'b0;
        wr_valid  = valid_q[ex_idx];
        wr_tag    = tag_q[ex_idx];
        wr_target = target_q[ex_idx];
`ifdef NPC_BHT_EN
        wr_ctr    = ctr_q[ex_idx];
`endif
        if (ex_valid && ex_is_branch) begin
            if (ex_hit && ex_taken) begin
                wr_en     = 1'b1;
                wr_target = ex_target;
`ifdef NPC_BHT_EN
                if (ctr_q[ex_idx] != 2'b11)
                    wr_ctr = ctr_q[ex_idx] + 2'b01;
`endif
            end else if (ex_hit) begin
                wr_en = 1'b1;
`ifdef NPC_BHT_EN
                if (ctr_q[ex_idx] != 2'b00)
                    wr_ctr = ctr_q[ex_idx] - 2'b01;
`else
                wr_valid = 1'b0;
`endif
            end else if (ex_taken) begin
                wr_en     = 1'b1;
                wr_valid  = 1'b1;
                wr_tag    = ex_pc[31:IDX+2];
                wr_target = ex_target;
`ifdef NPC_BHT_EN
                wr_ctr    = 2'b10;
`endif
            end
        end else if (ex_valid && ex_hit) begin
            wr_en    = 1'b1;
            wr_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= 32'd0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
`ifdef NPC_BHT_EN
                ctr_q[i]   <= 2'b01;
`endif
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            if (wr_en) begin
                valid_q[ex_idx] <= wr_valid;
`ifdef NPC_BHT_EN
                ctr_q[ex_idx]   <= wr_ctr;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_q[ex_idx]    <= wr_tag;
            target_q[ex_idx] <= wr_target;
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed scenarios plus randomized traffic
// against a table-based reference model. Define NPC_BHT_EN to match the RTL build.
module tb_next_pc_unit;

    localparam int N = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        stall;
    logic        ex_valid, ex_is_branch, ex_taken, ex_pred_taken;
    logic [31:0] ex_pc, ex_target, ex_pred_target;
    logic [31:0] pc_next, pred_target;
    logic        pred_taken, flush;

    int testsRun    = 0;
    int testsFailed = 0;

    // Reference BTB: one row per index, tag = pc / 64, index = (pc / 4) % 16.
    bit          mV   [N];
    int unsigned mTag [N];
    logic [31:0] mTgt [N];
    int          mCtr [N];
    bit          mPend;
    logic [31:0] mPendAddr;

    always #5 clk = ~clk;

    next_pc_unit #(.BTB_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .pc(pc), .stall(stall),
        .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_taken(ex_taken),
        .ex_pc(ex_pc), .ex_target(ex_target), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .pc_next(pc_next), .pred_taken(pred_taken),
        .pred_target(pred_target), .flush(flush)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [31:0] p, input logic s,
                                 input logic v, input logic br, input logic tk,
                                 input logic [31:0] epc, input logic [31:0] etg,
                                 input logic ept, input logic [31:0] eptg);
        rst = r; pc = p; stall = s;
        ex_valid = v; ex_is_branch = br; ex_taken = tk;
        ex_pc = epc; ex_target = etg; ex_pred_taken = ept; ex_pred_target = eptg;
    endtask

    function automatic int rowOf(input logic [31:0] a);
        return int'((a / 4) % N);
    endfunction

    function automatic bit hitsAt(input logic [31:0] a);
        return mV[rowOf(a)] && (mTag[rowOf(a)] == int'(a / 64));
    endfunction

    function automatic bit predictsTaken(input logic [31:0] a);
`ifdef NPC_BHT_EN
        return hitsAt(a) && (mCtr[rowOf(a)] >= 2);
`else
        return hitsAt(a);
`endif
    endfunction

    function automatic bit modelMis();
        if (!ex_valid) return 1'b0;
        if (!ex_is_branch) return ex_pred_taken;
        return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
    endfunction

    function automatic logic [31:0] modelRedir();
        return (ex_taken && ex_is_branch) ? ex_target : ex_pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < N; i++) begin
            mV[i] = 1'b0;
            mCtr[i] = 1;
        end
        mPend = 1'b0;
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic modelEdge();
        int r;
        bit h;
        if (rst) begin
            modelReset();
            return;
        end
        if (modelMis() && stall) begin
            mPend = 1'b1;
            mPendAddr = modelRedir();
        end else if (!stall) begin
            mPend = 1'b0;
        end
        r = rowOf(ex_pc);
        h = hitsAt(ex_pc);
        if (ex_valid && ex_is_branch) begin
            if (h && ex_taken) begin
                mTgt[r] = ex_target;
                mCtr[r] = (mCtr[r] < 3) ? mCtr[r] + 1 : 3;
            end else if (h) begin
`ifdef NPC_BHT_EN
                mCtr[r] = (mCtr[r] > 0) ? mCtr[r] - 1 : 0;
`else
                mV[r] = 1'b0;
`endif
            end else if (ex_taken) begin
                mV[r] = 1'b1;
                mTag[r] = int'(ex_pc / 64);
                mTgt[r] = ex_target;
                mCtr[r] = 2;
            end
        end else if (ex_valid && h) begin
            mV[r] = 1'b0;
        end
    endtask

    // Inputs are settled; compare against the model, then take the edge.
    task automatic runCycle(input string tag);
        logic [31:0] expTgt, expNext;
        bit expTk, mis;
        #1;
        expTk  = predictsTaken(pc);
        expTgt = expTk ? mTgt[rowOf(pc)] : pc + 32'd4;
        mis    = modelMis();
        expNext = mis ? modelRedir() : (mPend ? mPendAddr : expTgt);
        checkOutput({tag, ".pred_taken"}, {31'd0, pred_taken}, {31'd0, expTk});
        checkOutput({tag, ".pred_target"}, pred_target, expTgt);
        checkOutput({tag, ".pc_next"}, pc_next, expNext);
        checkOutput({tag, ".flush"}, {31'd0, flush}, {31'd0, mis});
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] p, input logic s);
        applyStimulus(1'b0, p, s, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
    endtask

    localparam logic [31:0] POOL [6] = '{32'h100, 32'h140, 32'h240, 32'h180, 32'h1C0, 32'hFFFFFFFC};

    initial begin
        logic [31:0] rp, re;
        modelReset();
        @(negedge clk);

        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        runCycle("reset0");
        #1;
        checkOutput("reset.pc_next", pc_next, 32'h104);
        checkOutput("reset.pred_taken", {31'd0, pred_taken}, 32'd0);
        checkOutput("reset.flush", {31'd0, flush}, 32'd0);
        runCycle("reset1");

        // Cold taken branch allocates and redirects.
        applyStimulus(1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b0, 32'h104);
        #1;
        checkOutput("cold.flush", {31'd0, flush}, 32'd1);
        checkOutput("cold.pc_next", pc_next, 32'h200);
        runCycle("cold");
        idle(32'h100, 1'b0);
        #1;
        checkOutput("cold.next.pred_taken", {31'd0, pred_taken}, 32'd1);
        checkOutput("cold.next.pc_next", pc_next, 32'h200);
        runCycle("cold.next");

        // Hysteresis: strengthen once, then two not-taken resolutions.
        applyStimulus(1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
        runCycle("hyst.strong");
        applyStimulus(1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, 1'b1, 32'h200);
        runCycle("hyst.nt1");
        idle(32'h100, 1'b0);
        #1;
`ifdef NPC_BHT_EN
        checkOutput("hyst.after1", {31'd0, pred_taken}, 32'd1);
`else
        checkOutput("hyst.after1", {31'd0, pred_taken}, 32'd0);
`endif
        runCycle("hyst.after1");
        applyStimulus(1'b0, 32'h100, 1'b0, 1'b1, 1'b1, 1'b0, 32'h100, 32'h200, predictsTaken(32'h100), 32'h200);
        runCycle("hyst.nt2");
        idle(32'h100, 1'b0);
        #1;
        checkOutput("hyst.after2", {31'd0, pred_taken}, 32'd0);
        checkOutput("hyst.after2.pc_next", pc_next, 32'h104);
        runCycle("hyst.after2");

        // Stalled mispredict parks the redirect.
        applyStimulus(1'b0, 32'h400, 1'b1, 1'b1, 1'b1, 1'b0, 32'h2FC, 32'h500, 1'b1, 32'h500);
        #1;
        checkOutput("stall.flush", {31'd0, flush}, 32'd1);
        checkOutput("stall.pc_next", pc_next, 32'h300);
        runCycle("stall.mis");
        for (int i = 0; i < 3; i++) begin
            idle(32'h400, 1'b1);
            #1;
            checkOutput("stall.hold.flush", {31'd0, flush}, 32'd0);
            checkOutput("stall.hold.pc_next", pc_next, 32'h300);
            runCycle("stall.hold");
        end
        idle(32'h400, 1'b0);
        #1;
        checkOutput("stall.release", pc_next, 32'h300);
        runCycle("stall.release");
        idle(32'h400, 1'b0);
        #1;
        checkOutput("stall.revert", pc_next, 32'h404);
        runCycle("stall.revert");

        // Alias clean-up.
        applyStimulus(1'b0, 32'h180, 1'b0, 1'b1, 1'b1, 1'b1, 32'h180, 32'h1C0, 1'b0, 32'h184);
        runCycle("alias.alloc");
        applyStimulus(1'b0, 32'h180, 1'b0, 1'b1, 1'b0, 1'b0, 32'h180, 32'h0, 1'b1, 32'h1C0);
        #1;
        checkOutput("alias.flush", {31'd0, flush}, 32'd1);
        checkOutput("alias.pc_next", pc_next, 32'h184);
        runCycle("alias");
        idle(32'h180, 1'b0);
        #1;
        checkOutput("alias.after", {31'd0, pred_taken}, 32'd0);
        runCycle("alias.after");

        // Wrap-around and same-index read/write.
        applyStimulus(1'b0, 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h10, 1'b1, 32'h10);
        #1;
        checkOutput("wrap.pc_next", pc_next, 32'h0);
        runCycle("wrap");
        applyStimulus(1'b0, 32'h240, 1'b0, 1'b1, 1'b1, 1'b1, 32'h240, 32'h280, 1'b0, 32'h244);
        runCycle("same.alloc");
        applyStimulus(1'b0, 32'h240, 1'b0, 1'b1, 1'b1, 1'b1, 32'h240, 32'h2C0, 1'b1, 32'h2C0);
        #1;
        checkOutput("same.old_target", pred_target, 32'h280);
        runCycle("same");
        idle(32'h240, 1'b0);
        #1;
        checkOutput("same.new_target", pred_target, 32'h2C0);
        runCycle("same.after");

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            rp = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : POOL[$urandom_range(0, 5)];
            re = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FFFC) : POOL[$urandom_range(0, 5)];
            applyStimulus(($urandom_range(0, 60) == 0), rp, ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) != 0),
                          1'($urandom_range(0, 1)), re,
                          ($urandom_range(0, 1) == 1) ? POOL[$urandom_range(0, 5)] : re + 32'd4,
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 1) == 1) ? POOL[$urandom_range(0, 5)] : re + 32'd4);
            if ($urandom_range(0, 1) == 1) ex_pred_taken = predictsTaken(ex_pc);
            runCycle("rand");
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
